sgd_memory_to_x_load: RTL

- Read-side counterpart of the x write-back path: loads the model x from memory and scatters it into per-engine x FIFOs.
- Once per epoch it issues one memory read command covering the whole model, then receives 512-bit lines.
- Routes each line to engine FIFOs: LINES_PER_ENGINE consecutive lines per engine, engines round-robin, repeated per dimension round.
- The line order is identical to the one the write-back path produces, so a written model reloads bit-exactly.

---
 rtl/sgd_memory_to_x_load_pkg.sv | 35 +++
 rtl/sgd_memory_to_x_load_x_line_router.sv | 76 +++++++
 rtl/sgd_memory_to_x_load.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/sgd_memory_to_x_load_pkg.sv
// Shared constants, FSM state encoding and error codes for the x load/write-back paths.
package sgd_memory_to_x_load_pkg;

  localparam int ENGINE_NUM        = 8;
  localparam int NUM_BITS_PER_BANK = 8;
  localparam int LINES_PER_ENGINE  = 4;
  localparam int LINE_BITS         = 512;
  localparam int DIMS_PER_ROUND    = ENGINE_NUM * NUM_BITS_PER_BANK;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_REQ  = 3'd1,
    ST_ISSUE_CMD = 3'd2,
    ST_RECV_DATA = 3'd3,
    ST_FINISH    = 3'd4
  } state_e;

  localparam logic [3:0] ERR_NONE      = 4'b0000;
  localparam logic [3:0] ERR_DIM_ZERO  = 4'b0001;
  localparam logic [3:0] ERR_DIM_ALIGN = 4'b0010;
  localparam logic [3:0] ERR_BEAT      = 4'b0100;

  function automatic logic [3:0] check_dimension(input logic [31:0] dim);
    logic [3:0] err;
    if (dim == 32'd0) begin
      err = ERR_DIM_ZERO;
    end else if ((dim % 32'(DIMS_PER_ROUND)) != 32'd0) begin
      err = ERR_DIM_ALIGN;
    end else begin
      err = ERR_NONE;
    end
    return err;
  endfunction

endpackage

// File: rtl/sgd_memory_to_x_load_x_line_router.sv
// Steps inner/engine/round counters per accepted line and issues the one-hot FIFO write a cycle later.
module sgd_x_line_router
  import sgd_memory_to_x_load_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  beat,
  input  logic [31:0]                           rounds,
  input  logic [LINE_BITS-1:0]                  line,
  output logic                                  last_beat,
  output logic [ENGINE_NUM-1:0][LINE_BITS-1:0]  wr_data,
  output logic [ENGINE_NUM-1:0]                 wr_en,
  output logic                                  load_done
);

  localparam int IW = $clog2(LINES_PER_ENGINE);
  localparam int EW = $clog2(ENGINE_NUM);

  logic [IW-1:0]         inner_r;
  logic [EW-1:0]         engine_r;
  logic [31:0]           round_r;
  logic [ENGINE_NUM-1:0] wr_en_r;
  logic [LINE_BITS-1:0]  data_r;
  logic                  done_r;
  logic                  last_inner_s;
  logic                  last_engine_s;
  logic                  last_round_s;

  assign last_inner_s  = (inner_r == IW'(LINES_PER_ENGINE - 1));
  assign last_engine_s = (engine_r == EW'(ENGINE_NUM - 1));
  assign last_round_s  = (round_r == (rounds - 32'd1));
  assign last_beat     = beat & last_inner_s & last_engine_s & last_round_s;

  // Line position counters and registered write strobe/data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inner_r  <= '0;
      engine_r <= '0;
      round_r  <= 32'd0;
      wr_en_r  <= '0;
      data_r   <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= last_beat;
      if (beat) begin
        wr_en_r <= {{(ENGINE_NUM-1){1'b0}}, 1'b1} << engine_r;
        data_r  <= line;
        if (last_inner_s) begin
          inner_r <= '0;
          if (last_engine_s) begin
            engine_r <= '0;
            round_r  <= last_round_s ? 32'd0 : (round_r + 32'd1);
          end else begin
            engine_r <= engine_r + EW'(1);
          end
        end else begin
          inner_r <= inner_r + IW'(1);
        end
      end else begin
        wr_en_r <= '0;
      end
    end
  end

  // Every lane carries the same line; only the enabled lane is written.
  always_comb begin
    wr_data = '0;
    for (int e = 0; e < ENGINE_NUM; e++) begin
      wr_data[e] = data_r;
    end
  end

  assign wr_en     = wr_en_r;
  assign load_done = done_r;

endmodule

// File: rtl/sgd_memory_to_x_load.sv
// Loads model x from memory once per epoch and scatters the lines into per-engine x FIFOs.
module sgd_memory_to_x_load
  import sgd_memory_to_x_load_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  started,
  input  logic [63:0]                           addr_model,
  input  logic [31:0]                           dimension,
  input  logic [31:0]                           numEpochs,
  input  logic                                  x_load_req,
  output logic                                  x_data_read_start,
  output logic [63:0]                           x_data_read_addr,
  output logic [31:0]                           x_data_read_length,
  input  logic                                  x_data_read_ready,
  input  logic [LINE_BITS-1:0]                  x_data_in,
  input  logic                                  x_data_in_valid,
  output logic                                  x_data_in_almost_full,
  output logic [ENGINE_NUM-1:0][LINE_BITS-1:0]  x_from_mem_wr_data,
  output logic [ENGINE_NUM-1:0]                 x_from_mem_wr_en,
  input  logic [ENGINE_NUM-1:0]                 x_from_mem_almost_full,
  output logic                                  x_load_done,
  output logic [3:0]                            error_state
);

  state_e      state_r;
  logic [3:0]  started_sr_r;
  logic [63:0] addr_r;
  logic [31:0] length_r;
  logic [31:0] rounds_r;
  logic [31:0] num_epochs_r;
  logic [31:0] epoch_idx_r;
  logic        start_r;
  logic [3:0]  err_r;
  logic        af_r;
  logic        arm_s;
  logic        beat_s;
  logic        stray_s;
  logic        last_beat_s;
  logic [3:0]  dim_err_s;

  assign arm_s     = (state_r == ST_IDLE) & started_sr_r[2] & ~started_sr_r[3];
  assign beat_s    = x_data_in_valid & (state_r == ST_RECV_DATA);
  assign stray_s   = x_data_in_valid & (state_r != ST_RECV_DATA);
  assign dim_err_s = check_dimension(dimension);

  // Epoch sequencing: arm, wait for request, issue one read command, collect the lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      started_sr_r <= 4'b0000;
      addr_r       <= 64'd0;
      length_r     <= 32'd0;
      rounds_r     <= 32'd0;
      num_epochs_r <= 32'd0;
      epoch_idx_r  <= 32'd0;
      start_r      <= 1'b0;
    end else begin
      started_sr_r <= {started_sr_r[2:0], started};
      case (state_r)
        ST_IDLE: begin
          if (arm_s) begin
            addr_r       <= addr_model;
            length_r     <= dimension << 5;
            rounds_r     <= dimension / 32'(DIMS_PER_ROUND);
            num_epochs_r <= numEpochs;
            epoch_idx_r  <= 32'd0;
            if (dim_err_s == ERR_NONE) begin
              state_r <= ST_WAIT_REQ;
            end
          end
        end
        ST_WAIT_REQ: begin
          if (epoch_idx_r == num_epochs_r) begin
            state_r <= ST_FINISH;
          end else if (x_load_req) begin
            state_r <= ST_ISSUE_CMD;
            start_r <= 1'b1;
          end
        end
        ST_ISSUE_CMD: begin
          if (x_data_read_ready) begin
            start_r     <= 1'b0;
            addr_r      <= addr_r + {32'd0, length_r};
            epoch_idx_r <= epoch_idx_r + 32'd1;
            state_r     <= ST_RECV_DATA;
          end
        end
        ST_RECV_DATA: begin
          if (last_beat_s) begin
            state_r <= ST_WAIT_REQ;
          end
        end
        ST_FINISH: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          start_r <= 1'b0;
        end
      endcase
    end
  end

  // Error flags: parameter check on arm, sticky flag for beats outside the data phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= ERR_NONE;
    end else if (arm_s) begin
      err_r <= dim_err_s | (stray_s ? ERR_BEAT : ERR_NONE);
    end else if (stray_s) begin
      err_r <= err_r | ERR_BEAT;
    end
  end

  // Upstream backpressure: any full FIFO, or not currently accepting data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      af_r <= 1'b0;
    end else begin
      af_r <= (|x_from_mem_almost_full) | (state_r != ST_RECV_DATA);
    end
  end

  sgd_x_line_router u_router (
    .clk       (clk),
    .rst_n     (rst_n),
    .beat      (beat_s),
    .rounds    (rounds_r),
    .line      (x_data_in),
    .last_beat (last_beat_s),
    .wr_data   (x_from_mem_wr_data),
    .wr_en     (x_from_mem_wr_en),
    .load_done (x_load_done)
  );

  assign x_data_read_start     = start_r;
  assign x_data_read_addr      = addr_r;
  assign x_data_read_length    = length_r;
  assign x_data_in_almost_full = af_r;
  assign error_state           = err_r;

endmodule
